promote_menu_ctrl: RTL and testbench

Sequences the pawn-promotion overlay. Accepts a promotion request from game logic and enables the 60x240 promotion sprite (four 60x60 cells, top to bottom: queen, rook, bishop, knight) for the promoting side's colour. Generates the registered sprite ROM address for the VGA pipeline, resolves a mouse click into a piece choice, and returns that choice to game logic with a valid/ack handshake.

---
 rtl/promote_menu_ctrl.sv | 142 ++++++++++++++
 tb/tb_promote_menu_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/promote_menu_ctrl.sv
// Pawn-promotion overlay sequencer: arms the 4-cell piece menu, generates the
// registered sprite ROM address, and returns the clicked piece via valid/ack.
module promote_menu_ctrl #(
    parameter int MENU_X0 = 290,
    parameter int MENU_Y0 = 120,
    parameter int CELL    = 60
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        promote_req,
    input  logic        promote_color,
    input  logic        promote_ack,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    input  logic        mouse_btn,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        menu_active,
    output logic        menu_color,
    output logic        pix_in_menu,
    output logic [13:0] rom_address,
    output logic [1:0]  hover_idx,
    output logic        hover_valid,
    output logic        promote_valid,
    output logic [1:0]  promote_piece,
    output logic        busy
);

    localparam logic [9:0]  X_LO   = 10'(MENU_X0);
    localparam logic [9:0]  X_HI   = 10'(MENU_X0 + CELL - 1);
    localparam logic [9:0]  Y_LO   = 10'(MENU_Y0);
    localparam logic [9:0]  Y_HI   = 10'(MENU_Y0 + 4 * CELL - 1);
    localparam logic [9:0]  C1     = 10'(CELL);
    localparam logic [9:0]  C2     = 10'(2 * CELL);
    localparam logic [9:0]  C3     = 10'(3 * CELL);
    localparam logic [13:0] CELL_W = 14'(CELL);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    state_t     state;
    logic       btn_q;
    logic       press;
    logic       mouse_in;
    logic       draw_in;
    logic [9:0] mouse_dy;
    logic [9:0] draw_dx;
    logic [9:0] draw_dy;
    logic [1:0] mouse_cell;

    // Both bounds are checked before subtracting, so coordinates left of or
    // above the origin never wrap into the region.
    always_comb begin
        mouse_in = (mouse_x >= X_LO) && (mouse_x <= X_HI) &&
                   (mouse_y >= Y_LO) && (mouse_y <= Y_HI);
        draw_in  = (DrawX >= X_LO) && (DrawX <= X_HI) &&
                   (DrawY >= Y_LO) && (DrawY <= Y_HI);
        mouse_dy = mouse_y - Y_LO;
        draw_dx  = DrawX - X_LO;
        draw_dy  = DrawY - Y_LO;
        if (mouse_dy < C1)
            mouse_cell = 2'd0;
        else if (mouse_dy < C2)
            mouse_cell = 2'd1;
        else if (mouse_dy < C3)
            mouse_cell = 2'd2;
        else
            mouse_cell = 2'd3;
        press = mouse_btn && !btn_q;
    end

    assign hover_valid = menu_active && mouse_in;
    assign hover_idx   = hover_valid ? mouse_cell : '0;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            btn_q         <= 1'b0;
            menu_active   <= 1'b0;
            menu_color    <= 1'b0;
            pix_in_menu   <= 1'b0;
            rom_address   <= '0;
            promote_valid <= 1'b0;
            promote_piece <= '0;
            busy          <= 1'b0;
        end else begin
            btn_q       <= mouse_btn;
            pix_in_menu <= menu_active && draw_in;
            if (menu_active && draw_in)
                rom_address <= 14'(draw_dx) + 14'(draw_dy) * CELL_W;
            else
                rom_address <= '0;

            case (state)
                IDLE: begin
                    if (promote_req) begin
                        menu_color  <= promote_color;
                        state       <= ARM;
                        menu_active <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ARM: begin
                    if (!mouse_btn)
                        state <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (press && mouse_in) begin
                        promote_piece <= mouse_cell;
                        state         <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!mouse_btn) begin
                        state         <= DONE;
                        menu_active   <= 1'b0;
                        promote_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (promote_ack) begin
                        state         <= IDLE;
                        promote_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    menu_active   <= 1'b0;
                    promote_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_promote_menu_ctrl.sv
// Self-checking bench for promote_menu_ctrl: vector table for address/hover
// decoding plus hand-written handshake and reset sequences.
module tb_promote_menu_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        promote_req;
    logic        promote_color;
    logic        promote_ack;
    logic [9:0]  mouse_x;
    logic [9:0]  mouse_y;
    logic        mouse_btn;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        menu_active;
    logic        menu_color;
    logic        pix_in_menu;
    logic [13:0] rom_address;
    logic [1:0]  hover_idx;
    logic        hover_valid;
    logic        promote_valid;
    logic [1:0]  promote_piece;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 vga_clk = ~vga_clk;

    promote_menu_ctrl #(.MENU_X0(290), .MENU_Y0(120), .CELL(60)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .promote_req(promote_req), .promote_color(promote_color),
        .promote_ack(promote_ack), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_btn(mouse_btn), .DrawX(DrawX), .DrawY(DrawY),
        .menu_active(menu_active), .menu_color(menu_color),
        .pix_in_menu(pix_in_menu), .rom_address(rom_address),
        .hover_idx(hover_idx), .hover_valid(hover_valid),
        .promote_valid(promote_valid), .promote_piece(promote_piece),
        .busy(busy)
    );

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [9:0]  mx;
        logic [9:0]  my;
        logic        exp_pix;
        logic [13:0] exp_rom;
        logic        exp_hv;
        logic [1:0]  exp_hi;
    } vec_t;

    typedef struct {
        logic        pix;
        logic [13:0] rom;
        logic        hv;
        logic [1:0]  hi;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned n = 0;
        while (promote_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("valid_within_budget", 32'(promote_valid), 32'd1);
    endtask

    task automatic click(input logic [9:0] x, input logic [9:0] y);
        mouse_x = x;
        mouse_y = y;
        mouse_btn = 1'b1;
        step();
        mouse_btn = 1'b0;
        step();
    endtask

    initial begin
        // {DrawX, DrawY, mouse_x, mouse_y, pix, rom, hover_valid, hover_idx}
        vecs[0]  = '{10'd349,  10'd359,  10'd300,  10'd179, 1'b1, 14'd14399, 1'b1, 2'd0};
        vecs[1]  = '{10'd290,  10'd120,  10'd300,  10'd180, 1'b1, 14'd0,     1'b1, 2'd1};
        vecs[2]  = '{10'd289,  10'd200,  10'd300,  10'd239, 1'b0, 14'd0,     1'b1, 2'd1};
        vecs[3]  = '{10'd350,  10'd200,  10'd300,  10'd240, 1'b0, 14'd0,     1'b1, 2'd2};
        vecs[4]  = '{10'd300,  10'd119,  10'd300,  10'd299, 1'b0, 14'd0,     1'b1, 2'd2};
        vecs[5]  = '{10'd300,  10'd360,  10'd300,  10'd300, 1'b0, 14'd0,     1'b1, 2'd3};
        vecs[6]  = '{10'd0,    10'd0,    10'd289,  10'd150, 1'b0, 14'd0,     1'b0, 2'd0};
        vecs[7]  = '{10'd1023, 10'd1023, 10'd350,  10'd150, 1'b0, 14'd0,     1'b0, 2'd0};
        vecs[8]  = '{10'd295,  10'd180,  10'd300,  10'd119, 1'b1, 14'd3605,  1'b0, 2'd0};
        vecs[9]  = '{10'd320,  10'd300,  10'd300,  10'd360, 1'b1, 14'd10830, 1'b0, 2'd0};
        vecs[10] = '{10'd349,  10'd120,  10'd1023, 10'd5,   1'b1, 14'd59,    1'b0, 2'd0};
        vecs[11] = '{10'd290,  10'd359,  10'd349,  10'd359, 1'b1, 14'd14340, 1'b1, 2'd3};

        reset_n = 1'b0;
        promote_req = 1'b0;
        promote_color = 1'b0;
        promote_ack = 1'b0;
        mouse_x = 10'd300;
        mouse_y = 10'd310;
        mouse_btn = 1'b1;
        DrawX = 10'd300;
        DrawY = 10'd200;
        step();
        step();
        check("rst_menu_active", 32'(menu_active), 32'd0);
        check("rst_menu_color", 32'(menu_color), 32'd0);
        check("rst_pix", 32'(pix_in_menu), 32'd0);
        check("rst_rom", 32'(rom_address), 32'd0);
        check("rst_valid", 32'(promote_valid), 32'd0);
        check("rst_piece", 32'(promote_piece), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hover_valid", 32'(hover_valid), 32'd0);
        reset_n = 1'b1;

        // Held click from the move is discarded while armed.
        promote_req = 1'b1;
        promote_color = 1'b1;
        step();
        promote_req = 1'b0;
        promote_color = 1'b0;
        check("arm_menu_active", 32'(menu_active), 32'd1);
        check("arm_menu_color", 32'(menu_color), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        repeat (3) step();
        check("held_active", 32'(menu_active), 32'd1);
        check("held_no_valid", 32'(promote_valid), 32'd0);
        mouse_btn = 1'b0;
        step();
        step();
        check("released_active", 32'(menu_active), 32'd1);
        check("released_no_valid", 32'(promote_valid), 32'd0);

        // Address and hover decoding while the menu is waiting for a press.
        for (int i = 0; i < 12; i++) begin
            DrawX = vecs[i].dx;
            DrawY = vecs[i].dy;
            mouse_x = vecs[i].mx;
            mouse_y = vecs[i].my;
            sb.push_back('{vecs[i].exp_pix, vecs[i].exp_rom, vecs[i].exp_hv, vecs[i].exp_hi});
            step();
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("vec%0d_pix", i), 32'(pix_in_menu), 32'(e.pix));
                check($sformatf("vec%0d_rom", i), 32'(rom_address), 32'(e.rom));
                check($sformatf("vec%0d_hover_valid", i), 32'(hover_valid), 32'(e.hv));
                check($sformatf("vec%0d_hover_idx", i), 32'(hover_idx), 32'(e.hi));
            end
        end

        // promote_req outside IDLE must not relatch the colour.
        promote_req = 1'b1;
        promote_color = 1'b0;
        step();
        promote_req = 1'b0;
        check("req_in_wait_color", 32'(menu_color), 32'd1);

        // Presses outside the overlay are ignored.
        click(10'd200, 10'd150);
        click(10'd290, 10'd119);
        click(10'd350, 10'd200);
        check("outside_active", 32'(menu_active), 32'd1);
        check("outside_no_valid", 32'(promote_valid), 32'd0);

        click(10'd290, 10'd120);
        wait_valid(4);
        check("queen_piece", 32'(promote_piece), 32'd0);
        check("queen_menu_off", 32'(menu_active), 32'd0);
        check("queen_busy", 32'(busy), 32'd1);
        promote_ack = 1'b1;
        step();
        promote_ack = 1'b0;
        check("queen_ack_valid", 32'(promote_valid), 32'd0);
        check("queen_ack_busy", 32'(busy), 32'd0);

        // Knight selection with held-off acknowledge.
        promote_req = 1'b1;
        promote_color = 1'b0;
        step();
        promote_req = 1'b0;
        step();
        mouse_x = 10'd300;
        mouse_y = 10'd310;
        mouse_btn = 1'b1;
        step();
        promote_ack = 1'b1;
        step();
        promote_ack = 1'b0;
        check("ack_outside_done", 32'(menu_active), 32'd1);
        mouse_x = 10'd100;
        mouse_y = 10'd100;
        mouse_btn = 1'b0;
        step();
        wait_valid(4);
        check("knight_piece", 32'(promote_piece), 32'd3);
        check("knight_color", 32'(menu_color), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("knight_hold%0d_valid", k), 32'(promote_valid), 32'd1);
            check($sformatf("knight_hold%0d_piece", k), 32'(promote_piece), 32'd3);
        end
        promote_ack = 1'b1;
        step();
        promote_ack = 1'b0;
        check("knight_ack_valid", 32'(promote_valid), 32'd0);
        step();
        check("knight_after_valid", 32'(promote_valid), 32'd0);

        // Inactive menu blanks the address path.
        DrawX = 10'd349;
        DrawY = 10'd359;
        step();
        check("inactive_pix", 32'(pix_in_menu), 32'd0);
        check("inactive_rom", 32'(rom_address), 32'd0);

        // Reset during WAIT_RELEASE.
        promote_req = 1'b1;
        step();
        promote_req = 1'b0;
        step();
        mouse_x = 10'd300;
        mouse_y = 10'd200;
        mouse_btn = 1'b1;
        step();
        step();
        check("pre_reset_rom", 32'(rom_address), 32'd14399);
        reset_n = 1'b0;
        step();
        check("midrst_active", 32'(menu_active), 32'd0);
        check("midrst_valid", 32'(promote_valid), 32'd0);
        check("midrst_rom", 32'(rom_address), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        mouse_btn = 1'b0;
        step();
        step();
        check("postrst_valid", 32'(promote_valid), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
